// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one frame per accepted i_TX_DV strobe, LSB first, line idles high.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_WIDTH  = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_TX_DV,
  input  logic [DATA_WIDTH-1:0] i_TX_Byte,
  output logic                  o_TX_Serial,
  output logic                  o_TX_Active,
  output logic                  o_TX_Done
);

  localparam int CW        = $clog2(CLK_PER_BIT);
  localparam int IDX_RANGE = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int BW        = (IDX_RANGE > 1) ? $clog2(IDX_RANGE) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLK_PER_BIT < 2 || DATA_WIDTH < 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx: illegal parameter value");
  end

  // state | meaning: IDLE wait for DV | START start bit | DATA data bits | PARITY parity bit | STOP stop bit(s) | CLEANUP done pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_clk_cnt;
  logic [BW-1:0]         r_bit_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_tx_serial;
  logic                  r_tx_active;
  logic                  r_tx_done;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_clk_cnt_nxt;
  logic [BW-1:0]         w_bit_idx_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_serial_nxt;
  logic                  w_active_nxt;
  logic                  w_done_nxt;
  logic                  w_bit_done;

`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
  logic                  w_parity_nxt;
`endif

  assign w_bit_done = (r_clk_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = '0;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_serial_nxt  = 1'b1;
    w_active_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_bit_idx_nxt = '0;
        if (i_TX_DV) begin
          w_state_nxt = S_START;
          w_data_nxt  = i_TX_Byte;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = (^i_TX_Byte) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (w_bit_done) w_state_nxt = S_DATA;
        else            w_clk_cnt_nxt = r_clk_cnt + 1'b1;
      end
      S_DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == DATA_LAST) begin
            w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = S_PARITY;
`else
            w_state_nxt   = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_done) w_state_nxt = S_STOP;
        else            w_clk_cnt_nxt = r_clk_cnt + 1'b1;
      end
`endif
      S_STOP: begin
        if (w_bit_done) begin
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_CLEANUP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_CLEANUP: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_idx_nxt = '0;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered without extra latency.
    case (w_state_nxt)
      S_START: begin
        w_serial_nxt = 1'b0;
        w_active_nxt = 1'b1;
      end
      S_DATA: begin
        w_serial_nxt = r_data[w_bit_idx_nxt];
        w_active_nxt = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_serial_nxt = r_parity;
        w_active_nxt = 1'b1;
      end
`endif
      S_STOP:    w_active_nxt = 1'b1;
      S_CLEANUP: w_done_nxt   = 1'b1;
      default:   w_serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_data      <= '0;
      r_tx_serial <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_data      <= w_data_nxt;
      r_tx_serial <= w_serial_nxt;
      r_tx_active <= w_active_nxt;
      r_tx_done   <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  assign o_TX_Serial = r_tx_serial;
  assign o_TX_Active = r_tx_active;
  assign o_TX_Done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: per-cycle timeline model plus serial-line decoder around uart_tx at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB        = 16;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS     = 1 + 8 + PAR + STOP_BITS;
  localparam int FRAME_CYC = NBITS * CPB;

  typedef struct {
    logic [7:0] tx_byte;
    int         dv2_at;
    logic [7:0] dv2_byte;
    int         rst_at;
    int         exp_frames;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       chk_en = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] rx_q[$];
  int         done_q[$];
  vec_t       tbl[7];

  uart_tx #(
    .CLK_PER_BIT(CPB),
    .DATA_WIDTH (8),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Serial(tx_serial),
    .o_TX_Active(tx_active),
    .o_TX_Done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(input int idx, input logic [7:0] b);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return (^b) ^ (PARITY_ODD != 0);
    return 1'b1;
  endfunction

  // Expected {serial, active, done} in cycle k after the accepting edge (k = 0: idle).
  function automatic logic [2:0] exp_out(input int k, input logic [7:0] b);
    if (k == 0) return 3'b100;
    if (k <= FRAME_CYC) return {frame_bit((k - 1) / CPB, b), 2'b10};
    return 3'b101;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_k <= 0;
    else if (m_k == 0) begin
      if (tx_dv) begin
        m_k    <= 1;
        m_byte <= tx_byte;
      end
    end else if (m_k == FRAME_CYC + 1) m_k <= 0;
    else m_k <= m_k + 1;
  end

  always @(negedge clk) begin
    if (chk_en) check("line_timeline", {29'd0, tx_serial, tx_active, tx_done}, {29'd0, exp_out(m_k, m_byte)});
    if (tx_done) done_q.push_back(cyc);
  end

  task automatic wait_n(input int n, inout bit ok);
    for (int i = 0; i < n; i++) begin
      if (!ok) return;
      @(negedge clk);
      if (rst) ok = 1'b0;
    end
  endtask

  // Independent receiver: mid-bit sampling from the detected falling edge, abandons on reset.
  initial begin : rx_decoder
    logic [7:0] d;
    bit         ok;
    forever begin
      @(negedge clk);
      if (chk_en && !rst && tx_serial === 1'b0) begin
        ok = 1'b1;
        d  = 8'h00;
        wait_n(CPB / 2, ok);
        if (ok) check("rx_start_bit", {31'd0, tx_serial}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          wait_n(CPB, ok);
          if (ok) d[i] = tx_serial;
        end
        if (PAR == 1) begin
          wait_n(CPB, ok);
          if (ok) check("rx_parity_bit", {31'd0, tx_serial}, {31'd0, (^d) ^ (PARITY_ODD != 0)});
        end
        for (int s = 0; s < STOP_BITS; s++) begin
          wait_n(CPB, ok);
          if (ok) check("rx_stop_bit", {31'd0, tx_serial}, 32'd1);
        end
        if (ok) rx_q.push_back(d);
      end
    end
  end

  task automatic apply_vec(input string name, input vec_t v);
    rx_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    tx_dv   = 1'b1;
    tx_byte = v.tx_byte;
    @(posedge clk); #1;
    tx_dv   = 1'b0;
    tx_byte = 8'($urandom);
    for (int k = 1; k <= FRAME_CYC + 60; k++) begin
      if (k == v.dv2_at) begin
        tx_dv   = 1'b1;
        tx_byte = v.dv2_byte;
      end
      if (k == v.rst_at) rst = 1'b1;
      @(posedge clk); #1;
      tx_dv = 1'b0;
      rst   = 1'b0;
    end
    check({name, "_frames"}, rx_q.size(), v.exp_frames);
    check({name, "_done_pulses"}, done_q.size(), v.exp_frames);
    if (rx_q.size() > 0) check({name, "_byte"}, {24'd0, rx_q[0]}, {24'd0, v.exp_byte});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t v;
    bit   found;
    // tx_byte, dv2_at, dv2_byte, rst_at, exp_frames, exp_byte
    tbl[0] = '{8'h55, -1,  8'h00, -1,  1, 8'h55};
    tbl[1] = '{8'hA3, 70,  8'hFF, -1,  1, 8'hA3};
    tbl[2] = '{8'h3C, -1,  8'h00, 100, 0, 8'h00};
    tbl[3] = '{8'h81, -1,  8'h00, -1,  1, 8'h81};
    tbl[4] = '{8'h07, -1,  8'h00, -1,  1, 8'h07};
    tbl[5] = '{8'h00, FRAME_CYC + 1, 8'hFF, -1, 1, 8'h00};
    tbl[6] = '{8'hC9, FRAME_CYC - 5, 8'h12, -1, 1, 8'hC9};

    rst = 1'b1; tx_dv = 1'b0; tx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Reset held for three cycles while idle.
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {29'd0, tx_serial, tx_active, tx_done}, 32'b100);

    // Reset and request in the same cycle: request dropped.
    rx_q.delete(); done_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; tx_dv = 1'b1; tx_byte = 8'h5A;
    @(posedge clk); #1;
    rst = 1'b0; tx_dv = 1'b0;
    repeat (FRAME_CYC + 10) @(posedge clk);
    #1;
    check("rst_dv_frames", rx_q.size(), 0);
    check("rst_dv_done", done_q.size(), 0);

    for (int i = 0; i < 7; i++) apply_vec($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back: request held high, byte changed once the first frame is underway.
    rx_q.delete(); done_q.delete();
    @(posedge clk); #1;
    tx_dv = 1'b1; tx_byte = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx_active) found = 1'b1;
    end
    check("b2b_first_accept", {31'd0, found}, 32'd1);
    tx_byte = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
      @(negedge clk);
      if (tx_active && done_q.size() == 1) found = 1'b1;
    end
    check("b2b_second_accept", {31'd0, found}, 32'd1);
    @(posedge clk); #1 tx_dv = 1'b0;
    repeat (FRAME_CYC + 40) @(posedge clk);
    #1;
    check("b2b_frames", rx_q.size(), 2);
    check("b2b_done_pulses", done_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_byte0", {24'd0, rx_q[0]}, 32'h00);
      check("b2b_byte1", {24'd0, rx_q[1]}, 32'hFF);
    end
    if (done_q.size() == 2) check("b2b_done_spacing", done_q[1] - done_q[0], FRAME_CYC + 2);

    // Random bytes, gaps and ignored intrusive requests.
    for (int r = 0; r < 20; r++) begin
      v.tx_byte    = 8'($urandom);
      v.dv2_at     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FRAME_CYC + 1)) : -1;
      v.dv2_byte   = 8'($urandom);
      v.rst_at     = -1;
      v.exp_frames = 1;
      v.exp_byte   = v.tx_byte;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      apply_vec($sformatf("rnd%0d", r), v);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. Serialises one byte per request onto the FPGA TX pin toward the PC: 8N1 at 115200 bps from the 100 MHz fabric clock.
- Companion of the existing UART receiver. Uses the same bit timing, so a loopback of o_TX_Serial into the receiver must reproduce the byte.
- Driven by user logic (switches, echo path) through a one-cycle data-valid strobe. Reports busy and done status.

Parameters:
- CLK_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Legal range >= 2. Counter width is $clog2(CLK_PER_BIT).
- DATA_WIDTH, 8, data bits per frame. Sent LSB first.
- STOP_BITS, 1, number of stop bits (1 or 2). Each stop bit is CLK_PER_BIT cycles.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd). Used only when UART_TX_PARITY_EN is defined.

Ports:
- i_clk  input  1  fabric clock, 100 MHz.
- i_rst  input  1  reset, synchronous, active-high.
- i_TX_DV  input  1  transmit request strobe. Sampled only in IDLE.
- i_TX_Byte  input  DATA_WIDTH  byte to send. Captured on the edge where i_TX_DV is accepted.
- o_TX_Serial  output  1  serial line. Idles high.
- o_TX_Active  output  1  high while a frame is in progress (START through STOP).
- o_TX_Done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_TX_Serial = 1, o_TX_Active = 0, o_TX_Done = 0.
  - State = IDLE. Bit counter, clock counter and shift register = 0.
- States: IDLE, START, DATA, [PARITY], STOP, CLEANUP. Any unused encoding goes to IDLE, line high.
- IDLE:
  - o_TX_Serial = 1, counters held at 0.
  - If i_TX_DV = 1 at an edge: latch i_TX_Byte and go to START. o_TX_Active rises on the same edge.
- START:
  - o_TX_Serial = 0 for exactly CLK_PER_BIT cycles (clock counter runs 0..CLK_PER_BIT-1), then go to DATA.
  - The line goes low on the first cycle after the accepting edge (latency 1 cycle).
- DATA:
  - o_TX_Serial = latched bit[idx] for CLK_PER_BIT cycles each, idx running 0..DATA_WIDTH-1.
  - Bit counter wraps to 0 after the last bit. Next state is PARITY when enabled, otherwise STOP.
- STOP:
  - o_TX_Serial = 1 for STOP_BITS*CLK_PER_BIT cycles, then go to CLEANUP.
- CLEANUP:
  - Lasts one cycle: o_TX_Done = 1, o_TX_Active = 0, line high.
  - Next state is IDLE.
- Frame length: from the accepting edge to the o_TX_Done cycle is (1 + DATA_WIDTH + STOP_BITS)*CLK_PER_BIT cycles. Add one bit time when parity is enabled.
- Request acceptance:
  - i_TX_DV outside IDLE (START through CLEANUP) is ignored. It is not queued and does not change the latched byte.
  - Changes on i_TX_Byte after acceptance have no effect on the frame.
- Back-to-back frames: the earliest next acceptance is the IDLE cycle after CLEANUP. The minimum idle-high gap between frames is 1 cycle (CLEANUP) plus the cycles spent in IDLE.
- Reset mid-frame:
  - On the next edge the line returns high and the state goes to IDLE.
  - o_TX_Active = 0. No o_TX_Done pulse. The partial frame is abandoned.
- Reset and i_TX_DV in the same cycle: reset wins, the request is dropped.
- Glitch-free output: o_TX_Serial is driven directly from a flop, never from combinational logic.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and lasts CLK_PER_BIT cycles.
  - The parity bit is the XOR of the latched data bits, inverted when PARITY_ODD = 1.
  - The parity bit is computed at latch time, from the latched value.
- Undefined:
  - No PARITY state, no parity logic. Frame is 8N1.
  - PARITY_ODD is ignored.

Test Plan:
- All scenarios use CLK_PER_BIT = 16 unless stated.
1. Reset: assert i_rst for 3 cycles mid-IDLE -> o_TX_Serial = 1, o_TX_Active = 0, o_TX_Done = 0 throughout and after release.
2. Single frame 0x55, 8N1:
   - Pulse i_TX_DV one cycle -> line low for 16 cycles starting 1 cycle later.
   - Then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles.
   - o_TX_Done pulses exactly 160 cycles after the accepting edge.
3. Ignored request:
   - Start 0xA3; assert i_TX_DV with 0xFF during DATA bit 3 -> frame still decodes as 0xA3.
   - No second frame; line stays high after CLEANUP.
4. Back-to-back and loopback:
   - Hold i_TX_DV high with 0x00 then 0xFF -> frames separated by at least 2 high cycles.
   - Loopback into the receiver at CLK_PER_BIT = 868 yields o_RX = 0x00, then 0xFF, each with an o_RX_DV pulse.
5. Reset mid-frame: i_rst during DATA bit 5 of 0x3C -> line high on the next edge, o_TX_Active = 0, no o_TX_Done pulse. A new 0x81 request after release transmits correctly.
6. Parity, UART_TX_PARITY_EN defined:
   - PARITY_ODD = 0, byte 0x07 -> parity bit 1. PARITY_ODD = 1, byte 0x07 -> parity bit 0.
   - o_TX_Done comes 176 cycles after acceptance.
